// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the flop-based FIFO.
// Used by the RTL and by its testbench.
package fifo_pkg;

  localparam int BITS_DEF  = 16;
  localparam int DEPTH_DEF = 8;

  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer: counts 0..depth-1 and returns to 0
// by explicit compare, so non-power-of-2 depths work.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int depth = DEPTH_DEF,
  parameter int pw    = ptr_w(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [pw-1:0] ptr
);

  localparam logic [pw-1:0] LAST = pw'(depth - 1);

  logic [pw-1:0] ptr_q;
  logic [pw-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flops_ext.sv
// First-word-fall-through FIFO on a flop array with level
// flags and sticky overflow/underflow error bits.
module fifo_flops_ext
  import fifo_pkg::*;
#(
  parameter int bits   = BITS_DEF,
  parameter int depth  = DEPTH_DEF,
  parameter int af_lvl = depth - 2,
  parameter int ae_lvl = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bits-1:0]           Din,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clr_err,
  output logic [bits-1:0]           Dout,
  output logic                      full,
  output logic                      pndng,
  output logic [cnt_w(depth)-1:0]   count,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CW = cnt_w(depth);
  localparam int PW = ptr_w(depth);

  localparam logic [CW-1:0] FULL_LVL = CW'(depth);
  localparam logic [CW-1:0] AF_LVL   = CW'(af_lvl);
  localparam logic [CW-1:0] AE_LVL   = CW'(ae_lvl);

  logic [bits-1:0] mem_q [depth];
  logic [bits-1:0] mem_d [depth];

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          udf_q;
  logic          udf_d;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == FULL_LVL);
  assign pndng = (count_q != '0);

  // A pop frees the slot in the same edge, so full+push+pop is legal.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && pndng;

  fifo_ptr #(
    .depth (depth),
    .pw    (PW)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(
    .depth (depth),
    .pw    (PW)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (do_pop),
    .ptr (rd_ptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr] = Din;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set events take priority over the clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (pop && !pndng) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign Dout         = pndng ? mem_q[rd_ptr] : '0;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flops_ext.sv
// Scoreboard bench for fifo_flops_ext: depth 8 directed
// sequences and a depth 5 directed wrap sequence.
module tb_fifo_flops_ext;
  import fifo_pkg::*;

  localparam int C8 = cnt_w(8);
  localparam int C5 = cnt_w(5);

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [15:0]   din8 = '0;
  logic          push8 = 1'b0;
  logic          pop8 = 1'b0;
  logic          clr8 = 1'b0;
  logic [15:0]   dout8;
  logic          full8;
  logic          pnd8;
  logic [C8-1:0] cnt8;
  logic          af8;
  logic          ae8;
  logic          ovf8;
  logic          udf8;

  logic [15:0]   din5 = '0;
  logic          push5 = 1'b0;
  logic          pop5 = 1'b0;
  logic          clr5 = 1'b0;
  logic [15:0]   dout5;
  logic          full5;
  logic          pnd5;
  logic [C5-1:0] cnt5;
  logic          af5;
  logic          ae5;
  logic          ovf5;
  logic          udf5;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb8[$];
  logic [15:0] sb5[$];
  int m8 = 0;
  int m5 = 0;
  logic m_ovf5 = 1'b0;
  logic m_udf5 = 1'b0;
  logic [1:0] v5 [20];

  always #5 clk = ~clk;

  fifo_flops_ext u_d8 (
    .clk (clk), .rst (rst), .Din (din8), .push (push8),
    .pop (pop8), .clr_err (clr8), .Dout (dout8),
    .full (full8), .pndng (pnd8), .count (cnt8),
    .almost_full (af8), .almost_empty (ae8),
    .overflow (ovf8), .underflow (udf8)
  );

  fifo_flops_ext #(.bits(16), .depth(5)) u_d5 (
    .clk (clk), .rst (rst), .Din (din5), .push (push5),
    .pop (pop5), .clr_err (clr5), .Dout (dout5),
    .full (full5), .pndng (pnd5), .count (cnt5),
    .almost_full (af5), .almost_empty (ae5),
    .overflow (ovf5), .underflow (udf5)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: every accepted pop must present the scoreboard head.
  always @(negedge clk) begin
    if (rst && pop8 && pnd8) begin
      n_tests++;
      if (sb8.size() == 0) begin
        n_fail++;
        $display("FAIL mon8: got %0h expected none", dout8);
      end else begin
        if (dout8 != sb8[0]) begin
          n_fail++;
          $display("FAIL mon8: got %0h expected %0h", dout8, sb8[0]);
        end
        void'(sb8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && pop5 && pnd5) begin
      n_tests++;
      if (sb5.size() == 0) begin
        n_fail++;
        $display("FAIL mon5: got %0h expected none", dout5);
      end else begin
        if (dout5 != sb5[0]) begin
          n_fail++;
          $display("FAIL mon5: got %0h expected %0h", dout5, sb5[0]);
        end
        void'(sb5.pop_front());
      end
    end
  end

  task automatic cyc8(input logic p, input logic q, input logic c,
                      input logic [15:0] d);
    bit ap;
    bit aq;
    push8 = p; pop8 = q; clr8 = c; din8 = d;
    ap = p && (m8 < 8 || q);
    aq = q && (m8 > 0);
    if (ap) sb8.push_back(d);
    m8 = m8 + int'(ap) - int'(aq);
    @(posedge clk);
    #1;
    push8 = 1'b0; pop8 = 1'b0; clr8 = 1'b0;
  endtask

  task automatic cyc5(input logic p, input logic q, input logic [15:0] d);
    bit ap;
    bit aq;
    push5 = p; pop5 = q; din5 = d;
    ap = p && (m5 < 5 || q);
    aq = q && (m5 > 0);
    if (p && m5 == 5 && !q) m_ovf5 = 1'b1;
    if (q && m5 == 0) m_udf5 = 1'b1;
    if (ap) sb5.push_back(d);
    m5 = m5 + int'(ap) - int'(aq);
    @(posedge clk);
    #1;
    push5 = 1'b0; pop5 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    v5 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11,
           2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01,
           2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01};

    #12;
    chk("rst_count", int'(cnt8), 0);
    chk("rst_dout", int'(dout8), 0);
    chk("rst_full", int'(full8), 0);
    chk("rst_pndng", int'(pnd8), 0);
    chk("rst_ae", int'(ae8), 1);
    chk("rst_af", int'(af8), 0);
    chk("rst_ovf", int'(ovf8), 0);
    chk("rst_udf", int'(udf8), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      cyc8(1'b1, 1'b0, 1'b0, 16'(i));
      chk("fill_count", int'(cnt8), i);
      chk("fill_af", int'(af8), int'(i >= 6));
      chk("fill_ae", int'(ae8), int'(i <= 2));
    end
    chk("fill_full", int'(full8), 1);
    chk("fill_dout", int'(dout8), 16'h0001);

    cyc8(1'b1, 1'b0, 1'b0, 16'hDEAD);
    chk("drop_ovf", int'(ovf8), 1);
    chk("drop_count", int'(cnt8), 8);
    for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, 1'b0, 16'h0);
    chk("drain_count", int'(cnt8), 0);
    chk("drain_dout", int'(dout8), 0);
    chk("drain_pndng", int'(pnd8), 0);
    cyc8(1'b0, 1'b0, 1'b1, 16'h0);
    chk("clr_ovf", int'(ovf8), 0);

    for (int i = 1; i <= 8; i++) cyc8(1'b1, 1'b0, 1'b0, 16'(i));
    cyc8(1'b1, 1'b1, 1'b0, 16'h0009);
    chk("fpp_count", int'(cnt8), 8);
    chk("fpp_ovf", int'(ovf8), 0);
    chk("fpp_dout", int'(dout8), 16'h0002);
    for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, 1'b0, 16'h0);
    chk("wrap_count", int'(cnt8), 0);

    cyc8(1'b1, 1'b1, 1'b0, 16'h00AA);
    chk("epp_count", int'(cnt8), 1);
    chk("epp_udf", int'(udf8), 1);
    chk("epp_dout", int'(dout8), 16'h00AA);
    cyc8(1'b0, 1'b0, 1'b1, 16'h0);
    chk("clr_udf", int'(udf8), 0);
    cyc8(1'b0, 1'b1, 1'b0, 16'h0);
    cyc8(1'b0, 1'b1, 1'b1, 16'h0);
    chk("udf_wins", int'(udf8), 1);
    cyc8(1'b0, 1'b0, 1'b1, 16'h0);
    chk("udf_clr2", int'(udf8), 0);

    for (int i = 0; i < 20; i++) begin
      cyc5(v5[i][1], v5[i][0], 16'(16'h0100 + i));
      chk("d5_count", int'(cnt5), m5);
      chk("d5_max", int'(cnt5 <= 3'd5), 1);
    end
    chk("d5_ovf", int'(ovf5), int'(m_ovf5));
    chk("d5_udf", int'(udf5), int'(m_udf5));

    for (int i = 0; i < 3; i++) cyc8(1'b1, 1'b0, 1'b0, 16'(16'h0030 + i));
    chk("pre_rst_count", int'(cnt8), 3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", int'(cnt8), 0);
    chk("arst_pndng", int'(pnd8), 0);
    chk("arst_dout", int'(dout8), 0);
    sb8.delete();
    m8 = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc8(1'b1, 1'b0, 1'b0, 16'h0055);
    chk("post_dout", int'(dout8), 16'h0055);
    cyc8(1'b0, 1'b1, 1'b0, 16'h0);
    chk("post_count", int'(cnt8), 0);

    @(posedge clk);
    #1;
    chk("sb8_empty", sb8.size(), 0);
    chk("sb5_empty", sb5.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_flops_ext.md
FIFO_FLOPS_EXT -- requirements
Module: fifo_flops_ext

Interface
REQ-001 SHALL have parameter bits, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter depth, default 8, number of entries (>=2); non-power-of-2 values are legal.
REQ-003 SHALL have parameter af_lvl, default depth-2: almost_full asserts when count >= af_lvl.
REQ-004 SHALL have parameter ae_lvl, default 2: almost_empty asserts when count <= ae_lvl.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Din, input, bits, write data.
REQ-008 SHALL have port push, input, 1, write request.
REQ-009 SHALL have port pop, input, 1, read request.
REQ-010 SHALL have port clr_err, input, 1, synchronous clear of the sticky error flags.
REQ-011 SHALL have port Dout, output, bits, head-of-queue data.
REQ-012 SHALL have port full, output, 1, count == depth.
REQ-013 SHALL have port pndng, output, 1, count != 0.
REQ-014 SHALL have port count, output, $clog2(depth+1), current occupancy.
REQ-015 SHALL have port almost_full, output, 1, count >= af_lvl.
REQ-016 SHALL have port almost_empty, output, 1, count <= ae_lvl.
REQ-017 SHALL have port overflow, output, 1, sticky flag for a dropped push.
REQ-018 SHALL have port underflow, output, 1, sticky flag for an ignored pop.

Function
REQ-019 The FIFO SHALL be first-word-fall-through: Dout equals the oldest entry whenever pndng=1, with zero cycles from write to visibility after the push edge.
REQ-020 Dout SHALL be all-zero whenever pndng=0.
REQ-021 A push with full=0 SHALL write Din at wr_ptr and advance wr_ptr.
REQ-022 A pop with pndng=1 SHALL advance rd_ptr.
REQ-023 Pointers SHALL wrap from depth-1 to 0 with explicit compare, not modulo-2^n.
REQ-024 A push with full=1 and pop=0 SHALL be dropped, leave memory, pointers and count unchanged, and set overflow.
REQ-025 A pop with pndng=0 SHALL be ignored and SHALL set underflow.
REQ-026 A simultaneous push and pop with full=1 SHALL both be accepted; count stays at depth; overflow is not set.
REQ-027 A simultaneous push and pop with pndng=0 SHALL accept the push only (count becomes 1) and SHALL set underflow.
REQ-028 A simultaneous push and pop with 0<count<depth SHALL leave count unchanged.
REQ-029 count SHALL be a registered counter (+1 push-only, -1 pop-only, else hold); full, pndng, almost_full and almost_empty SHALL decode from it combinationally.
REQ-030 overflow and underflow SHALL hold once set until clr_err=1 or reset; a set event in the same cycle as clr_err SHALL win.

Reset
REQ-031 rst=0 SHALL, asynchronously, clear wr_ptr, rd_ptr and count to 0, and clear overflow and underflow to 0.
REQ-032 During and after reset: Dout=0, full=0, pndng=0, almost_empty=1, almost_full=0 (for af_lvl>0).
REQ-033 Memory contents SHALL NOT require reset; stale data SHALL never appear on Dout because of REQ-020.
REQ-034 Deassertion of rst mid-stream SHALL leave the FIFO empty; pushes in flight at the reset edge are lost.

Structure
REQ-035 Package fifo_pkg SHALL hold the default bits and depth constants and a count-width function, shared by this block and its testbench interface.
REQ-036 Storage SHALL be a flop array, depth x bits; no sub-module is needed beyond optional fifo_ptr (wrap-around pointer counter, instantiated twice).

Verification
REQ-037 Reset, then 8 pushes 0x0001..0x0008 -> full=1, count=8, almost_full from count=6, Dout=0x0001.
REQ-038 From full, push 0xDEAD alone -> overflow=1, count=8; 8 pops return 0x0001..0x0008 in order, DEAD never seen.
REQ-039 From full, push 0x0009 and pop together -> count=8, overflow=0, Dout=0x0002; drain to verify wrap order 0x0002..0x0009.
REQ-040 Empty, push 0x00AA and pop together -> count=1, underflow=1, Dout=0x00AA; clr_err -> underflow=0.
REQ-041 depth=5: 20 random push/pop cycles -> scoreboard match, count never exceeds 5, pointers wrap 4->0.
REQ-042 rst=0 asserted mid-cycle with count=3 -> immediate count=0, pndng=0, Dout=0 without a clock edge.
